// File: rtl/hcp_dmux_pkg.sv
// Shared definitions for the HCP frame dispatcher: FSM encoding, the TSMP frame
// type and the width and saturation helper for the statistics counters.
package hcp_dmux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRANS = 2'd1,
    DISC  = 2'd2
  } dmux_state_e;

  localparam logic [15:0] TSMP_TYPE = 16'hff01;
  localparam int unsigned CNT_W     = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dmux_route_sel.sv
// Combinational priority match of a frame type against the per-lane table;
// the lowest enabled lane whose type matches wins.
module dmux_route_sel #(
  parameter int NUM_OUT = 4,
  parameter int LANE_W  = 2
) (
  input  logic [NUM_OUT*16-1:0] match_type,
  input  logic [NUM_OUT-1:0]    match_vld,
  input  logic [15:0]           frame_type,
  output logic [LANE_W-1:0]     lane,
  output logic                  hit
);

  always_comb begin
    lane = '0;
    hit  = 1'b0;
    // Scan from the top so the lowest matching index is assigned last.
    for (int unsigned k = NUM_OUT; k > 0; k--) begin
      if (match_vld[k-1] && (match_type[(k-1)*16 +: 16] == frame_type)) begin
        lane = LANE_W'(k - 1);
        hit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmux_nway.sv
// N-way frame dispatcher: routes each frame to one registered output lane by type,
// gated by configuration stage, with over-length truncation.
// Optional DMUX_STAT_EN adds saturating stage-discard and truncation counters.
module dmux_nway
  import hcp_dmux_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DESC_W  = 35,
  parameter int NUM_OUT = 4,
  parameter int DEF_OUT = 0,
  parameter int MAX_LEN = 2048
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [1:0]                    iv_cfg_finish,
  input  logic [NUM_OUT*16-1:0]         iv_match_type,
  input  logic [NUM_OUT-1:0]            iv_match_vld,
  input  logic [NUM_OUT*2-1:0]          iv_min_stage,
  input  logic [DATA_W:0]               iv_data,
  input  logic                          i_data_wr,
  input  logic [DESC_W-1:0]             iv_descriptor,
  output logic [NUM_OUT*(DATA_W+1)-1:0] ov_data,
  output logic [NUM_OUT*DESC_W-1:0]     ov_descriptor,
  output logic [NUM_OUT-1:0]            ov_data_wr,
  output logic [31:0]                   ov_disc_cnt
);

  localparam int LANE_W = $clog2(NUM_OUT);
  localparam int LEN_W  = $clog2(MAX_LEN) + 1;
  localparam int BEAT_W = DATA_W + 1;

  generate
    if (MAX_LEN < 2) begin : g_bad_max_len
      $error("dmux_nway: MAX_LEN must be at least 2");
    end
    if (NUM_OUT < 2 || NUM_OUT > 8) begin : g_bad_num_out
      $error("dmux_nway: NUM_OUT must be in 2..8");
    end
    if (DEF_OUT < 0 || DEF_OUT >= NUM_OUT) begin : g_bad_def_out
      $error("dmux_nway: DEF_OUT must index an existing lane");
    end
  endgenerate

  dmux_state_e         state;
  logic [LANE_W-1:0]   lane_q;
  logic [LEN_W-1:0]    len_cnt;
  logic [LANE_W-1:0]   match_lane;
  logic                match_hit;
  logic [LANE_W-1:0]   sel_lane;
  logic                flag;
  logic                head;
  logic                stage_ok;
  logic                stage_drop;
  logic                at_limit;
  logic                trunc_hit;

  dmux_route_sel #(
    .NUM_OUT (NUM_OUT),
    .LANE_W  (LANE_W)
  ) u_route_sel (
    .match_type (iv_match_type),
    .match_vld  (iv_match_vld),
    .frame_type (iv_descriptor[15:0]),
    .lane       (match_lane),
    .hit        (match_hit)
  );

  assign flag       = iv_data[DATA_W];
  assign head       = (state == IDLE) && i_data_wr && flag;
  assign sel_lane   = match_hit ? match_lane : LANE_W'(DEF_OUT);
  assign stage_ok   = iv_cfg_finish >= iv_min_stage[2*int'(sel_lane) +: 2];
  assign stage_drop = head && !stage_ok;
  // The head is the first valid beat, so len_cnt == MAX_LEN-1 marks the MAX_LEN-th.
  assign at_limit   = len_cnt == LEN_W'(MAX_LEN - 1);
  assign trunc_hit  = (state == TRANS) && i_data_wr && !flag && at_limit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      lane_q        <= '0;
      len_cnt       <= '0;
      ov_data       <= '0;
      ov_descriptor <= '0;
      ov_data_wr    <= '0;
    end else begin
      ov_data       <= '0;
      ov_descriptor <= '0;
      ov_data_wr    <= '0;
      case (state)
        IDLE: begin
          if (head) begin
            len_cnt <= LEN_W'(1);
            if (stage_drop) begin
              state <= DISC;
            end else begin
              lane_q                                          <= sel_lane;
              ov_data[int'(sel_lane)*BEAT_W +: BEAT_W]        <= iv_data;
              ov_descriptor[int'(sel_lane)*DESC_W +: DESC_W]  <= iv_descriptor;
              ov_data_wr[sel_lane]                            <= 1'b1;
              state                                           <= TRANS;
            end
          end
        end
        TRANS: begin
          if (i_data_wr) begin
            len_cnt                                       <= len_cnt + 1'b1;
            ov_data[int'(lane_q)*BEAT_W +: BEAT_W]        <= iv_data;
            ov_descriptor[int'(lane_q)*DESC_W +: DESC_W]  <= iv_descriptor;
            ov_data_wr[lane_q]                            <= 1'b1;
            if (flag) begin
              state <= IDLE;
            end else if (trunc_hit) begin
              // Later assignment overrides the copied flag bit to close the frame.
              ov_data[int'(lane_q)*BEAT_W + DATA_W] <= 1'b1;
              state                                 <= DISC;
            end
          end
        end
        DISC: begin
          if (i_data_wr && flag) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMUX_STAT_EN
  logic [CNT_W-1:0] stage_cnt;
  logic [CNT_W-1:0] trunc_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stage_cnt <= '0;
      trunc_cnt <= '0;
    end else begin
      if (stage_drop) stage_cnt <= sat_inc(stage_cnt);
      if (trunc_hit)  trunc_cnt <= sat_inc(trunc_cnt);
    end
  end

  assign ov_disc_cnt = {trunc_cnt, stage_cnt};
`else
  assign ov_disc_cnt = '0;
`endif

endmodule
